// File: rtl/ctx_fetch.sv
// ctx_fetch: context sequencer between the context RAM read port and the
// PE-array configuration stream.
//
// A start command walks base_addr, base_addr+1, ... (mod 2**AWIDTH) for
// num_ctx words. It repeats that pass loop_cnt more times. Each word is
// presented on a valid/ready stream.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             1-cycle command; ignored while busy
//   base_addr         first address of a pass (sampled at the accepted start)
//   num_ctx           words per pass, 0..2**AWIDTH (sampled at start)
//   loop_cnt          extra passes; total passes = loop_cnt+1 (sampled at start)
//   abort             synchronous cancel; has priority over start
//   busy, done        run in progress / 1-cycle completion pulse
//   ram_en, ram_addr  RAM read request
//   ram_dout          RAM read data, valid the cycle after ram_en
//   ctx_valid/ctx_data/ctx_last/ctx_ready  output stream
//
// Stream handshake: a word transfers in a cycle where ctx_valid && ctx_ready.
// While ctx_valid && !ctx_ready, ctx_valid, ctx_data and ctx_last are held.
// ctx_valid never waits on ctx_ready.
//
// Storage: the RAM output register is the landing stage for a read. A word
// is visible on the stream in the cycle it lands. If that word is not
// accepted, it moves into a 2-entry FIFO. Reads are issued only when the
// landing stage plus the FIFO can hold the result. As a result, no word
// that has been read is ever dropped.
module ctx_fetch #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   num_ctx,
  input  logic [LWIDTH-1:0] loop_cnt,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              ctx_valid,
  output logic [DWIDTH-1:0] ctx_data,
  output logic              ctx_last,
  input  logic              ctx_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [AWIDTH-1:0] base_q;
  logic [AWIDTH:0]   num_q;
  logic [AWIDTH:0]   word_idx;
  logic [LWIDTH-1:0] pass_left;
  logic              inflight;
  logic              inflight_last;
  logic [DWIDTH-1:0] buf_data [2];
  logic [1:0]        buf_last;
  logic [1:0]        buf_count;
  logic              rd_ptr;
  logic              wr_ptr;

  logic              pop;
  logic              push;
  logic              pop_buf;
  logic              issue_last;
  logic              run_end;
  logic [2:0]        occ_after;

  assign pop       = ctx_valid && ctx_ready;
  // Occupancy after this cycle's pop: buffered words plus the landing word.
  assign occ_after = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign ram_en    = (state == FETCH) && (occ_after < 3'd2);
  assign issue_last = (word_idx == num_q - 1'b1);

  assign ctx_valid = (buf_count != 2'd0) || inflight;
  // With an empty FIFO, the landing word is presented directly.
  assign ctx_data  = (buf_count == 2'd0 && inflight) ? ram_dout : buf_data[rd_ptr];
  assign ctx_last  = (buf_count == 2'd0 && inflight) ? inflight_last : buf_last[rd_ptr];

  // A landing word enters the FIFO unless it is consumed straight from the RAM.
  assign push    = inflight && !(buf_count == 2'd0 && pop);
  assign pop_buf = pop && (buf_count != 2'd0);
  // In DRAIN, every outstanding word is already landed or buffered.
  // Popping the only remaining one ends the run.
  assign run_end = (state == DRAIN) && pop &&
                   (({1'b0, buf_count} + {2'b00, inflight}) == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_addr      <= '0;
      base_q        <= '0;
      num_q         <= '0;
      word_idx      <= '0;
      pass_left     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
      buf_last      <= '0;
      buf_count     <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= ram_en;
      inflight_last <= issue_last;
      if (abort) begin
        // The read issued this cycle (if any) is dropped by clearing inflight.
        state     <= IDLE;
        busy      <= 1'b0;
        inflight  <= 1'b0;
        buf_count <= '0;
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
      end else begin
        if (push) begin
          buf_data[wr_ptr] <= ram_dout;
          buf_last[wr_ptr] <= inflight_last;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop_buf) rd_ptr <= ~rd_ptr;
        buf_count <= buf_count + {1'b0, push} - {1'b0, pop_buf};

        case (state)
          IDLE: begin
            if (start) begin
              if (num_ctx == '0) begin
                done <= 1'b1;
              end else begin
                state     <= FETCH;
                busy      <= 1'b1;
                base_q    <= base_addr;
                num_q     <= num_ctx;
                pass_left <= loop_cnt;
                word_idx  <= '0;
                ram_addr  <= base_addr;
              end
            end
          end
          FETCH: begin
            if (ram_en) begin
              if (issue_last) begin
                word_idx <= '0;
                ram_addr <= base_q;
                if (pass_left == '0) state <= DRAIN;
                else pass_left <= pass_left - 1'b1;
              end else begin
                word_idx <= word_idx + 1'b1;
                ram_addr <= ram_addr + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (run_end) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctx_fetch.sv
// tb_ctx_fetch: directed and randomized stimulus for ctx_fetch.
// A behavioural model expands each accepted command into the ordered list
// of addresses and words it must produce. Checks are compared against that
// list at the falling edge.
module tb_ctx_fetch;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_ctx = '0;
  logic [LW-1:0] loop_cnt = '0;
  logic          abort = 1'b0;
  logic          busy, done, ram_en, ctx_valid, ctx_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] ctx_data;
  logic          ctx_ready = 1'b1;

  ctx_fetch #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_ctx(num_ctx), .loop_cnt(loop_cnt), .abort(abort), .busy(busy),
    .done(done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ctx_valid(ctx_valid), .ctx_data(ctx_data), .ctx_last(ctx_last),
    .ctx_ready(ctx_ready)
  );

  // Context RAM: 1-cycle read latency; the output holds when en=0.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0]   exp_q[$];   // {last, data}
  logic [AW-1:0] addr_q[$];
  bit   m_busy, pending_done, abort_prev, prev_stall;
  logic [DW:0] prev_word;
  int   occ, hs_total;
  bit   rdy_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s observed=event expected=none", tag);
  endtask

  // Monitor and reference model, evaluated at the falling edge.
  always @(negedge clk) begin
    bit hs, busy_now, nxt_done;
    logic [DW:0] w;
    int a;
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      m_busy = 0; pending_done = 0; abort_prev = 0; prev_stall = 0;
      occ = 0;
    end else begin
      hs = ctx_valid && ctx_ready;
      busy_now = m_busy;
      nxt_done = 0;
      chk("busy", busy, m_busy);
      chk("done", done, pending_done);
      if (abort_prev) chk("abort_valid", ctx_valid, 0);
      if (prev_stall && !abort_prev) begin
        chk("stall_valid", ctx_valid, 1);
        chk("stall_word", {ctx_last, ctx_data}, prev_word);
      end
      n_checks++;
      assert (occ <= 2) else begin
        n_fail++;
        $error("FAIL occupancy observed=%0d expected=<=2", occ);
      end
      if (ram_en) begin
        n_checks++;
        assert (occ - int'(hs) <= 1) else begin
          n_fail++;
          $error("FAIL issue_when_full observed=%0d expected=<=1", occ - int'(hs));
        end
        if (addr_q.size() == 0) fail_now("unexpected_ram_en");
        else chk("ram_addr", ram_addr, addr_q.pop_front());
      end
      if (hs) begin
        hs_total++;
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else begin
          w = exp_q.pop_front();
          chk("ctx_data", ctx_data, w[DW-1:0]);
          chk("ctx_last", ctx_last, w[DW]);
          if (exp_q.size() == 0 && m_busy) begin
            nxt_done = 1;
            m_busy = 0;
          end
        end
      end
      occ = occ + int'(ram_en) - int'(hs);
      if (abort) begin
        exp_q.delete();
        addr_q.delete();
        m_busy = 0; occ = 0; nxt_done = 0;
      end else if (start && !busy_now) begin
        if (num_ctx == 0) nxt_done = 1;
        else begin
          m_busy = 1;
          for (int p = 0; p <= int'(loop_cnt); p++)
            for (int i = 0; i < int'(num_ctx); i++) begin
              a = (int'(base_addr) + i) % DEPTH;
              addr_q.push_back(AW'(a));
              exp_q.push_back({(i == int'(num_ctx) - 1), mem[a]});
            end
        end
      end
      pending_done = nxt_done;
      abort_prev   = abort;
      prev_stall   = ctx_valid && !ctx_ready;
      prev_word    = {ctx_last, ctx_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rdy_rand) ctx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_cmd(input int b, input int n, input int l);
    base_addr = AW'(b);
    num_ctx   = (AW+1)'(n);
    loop_cnt  = LW'(l);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_busy || pending_done || exp_q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) fail_now("run_timeout");
    cycle();
    @(negedge clk);
    chk("idle_valid", ctx_valid, 0);
    cycle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_valid", ctx_valid, 0);
    chk("rst_last", ctx_last, 0);
    chk("rst_data", ctx_data, 0);
    chk("rst_addr", ram_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // Basic run with latency checks.
    start_cmd(5, 4, 0);
    @(negedge clk);
    chk("lat_ram_en", ram_en, 1);
    chk("lat_ram_addr", ram_addr, 5);
    chk("lat_valid_early", ctx_valid, 0);
    cycle();
    @(negedge clk);
    chk("lat_valid", ctx_valid, 1);
    chk("lat_data", ctx_data, mem[5]);
    wait_idle(50);

    // Address wrap.
    start_cmd(1022, 4, 0);
    wait_idle(50);

    // Backpressure with a 5-cycle stall.
    rdy_rand = 1'b1;
    start_cmd(40, 8, 0);
    repeat (3) cycle();
    rdy_rand = 1'b0;
    ctx_ready = 1'b0;
    repeat (4) cycle();
    @(negedge clk);
    chk("bp_full_ram_en", ram_en, 0);
    chk("bp_full_valid", ctx_valid, 1);
    rdy_rand = 1'b1;
    cycle();
    wait_idle(200);

    // Repeat passes.
    rdy_rand = 1'b0;
    ctx_ready = 1'b1;
    start_cmd(16, 3, 2);
    wait_idle(100);

    // Zero-length command.
    start_cmd(77, 0, 3);
    wait_idle(20);

    // Start while busy is ignored.
    start_cmd(100, 6, 0);
    cycle();
    start_cmd(200, 2, 1);
    wait_idle(100);

    // Abort after 3 words, then a clean restart.
    start_cmd(500, 10, 0);
    k = 0;
    while (hs_total < 3 && k < 50) begin cycle(); k++; end
    // Each run has already reset the handshake counter to 0.
    if (k >= 50) fail_now("abort_wait_timeout");
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();
    start_cmd(300, 5, 0);
    wait_idle(100);

    // Full address space in one pass.
    rdy_rand = 1'b1;
    start_cmd(7, DEPTH, 0);
    wait_idle(5000);

    // Randomized commands under random backpressure.
    for (int r = 0; r < 8; r++) begin
      start_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), $urandom_range(0, 3));
      wait_idle(600);
    end

    // Asynchronous reset mid-run.
    rdy_rand = 1'b0;
    ctx_ready = 1'b1;
    start_cmd(60, 20, 0);
    repeat (4) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_valid", ctx_valid, 0);
    chk("mid_rst_last", ctx_last, 0);
    chk("mid_rst_data", ctx_data, 0);
    chk("mid_rst_addr", ram_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    start_cmd(900, 3, 1);
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Per-run handshake count: clear it whenever a command is launched.
  always @(posedge clk) if (start) hs_total = 0;

endmodule
